smart_lock_ctrl: RTL and testbench
==================================

// Module: smart_lock_ctrl
// PURPOSE
//  Keypad/remote door-lock controller. Collects a multi-digit code one digit at a time and checks it
//  against a main code and an optional temporary code. Adds an auto-relock timer, an entry timeout and
//  a lockout after repeated failures. Sits between keypad scanner, home-hub remote link and the lock actuator.
// PARAMETERS
//  DIGIT_W        4     bits per keypad digit
//  CODE_LEN       4     digits per code (>=1)
//  MAX_FAILS      3     consecutive wrong codes before lockout (>=1)
//  LOCKOUT_CYC    1000  cycles spent in lockout
//  RELOCK_CYC     500   cycles unlocked before auto-relock
//  ENTRY_TO_CYC   200   idle cycles mid-entry before the partial code is discarded
// PORTS
//  clk           in   1                  clock
//  rst           in   1                  reset, asynchronous, active-high
//  key_valid     in   1                  one-cycle strobe: key_digit holds a new digit
//  key_digit     in   DIGIT_W            digit value
//  main_code     in   CODE_LEN*DIGIT_W   main code; first digit entered = MS digit
//  temp_code     in   CODE_LEN*DIGIT_W   temporary code, same ordering
//  temp_code_en  in   1                  temp_code is accepted only while this is 1
//  remote_unlock in   1                  unlock request from hub (level, sampled per cycle)
//  remote_lock   in   1                  lock request from hub
//  lock_state    out  1                  0 = locked, 1 = unlocked
//  lockout       out  1                  1 while in LOCKOUT
//  entry_busy    out  1                  1 while a partial code is held (ENTRY)
//  fail_count    out  $clog2(MAX_FAILS+1) consecutive failed attempts
//  bad_code      out  1                  one-cycle pulse on a wrong complete code
// BEHAVIOUR
//  Reset: state LOCKED; all outputs 0; digit count, shift register and timer cleared.
//  States: LOCKED, ENTRY, UNLOCKED, LOCKOUT. lock_state=1 only in UNLOCKED.
//  Priority each cycle: remote_unlock > remote_lock > timers > keypad.
//  remote_unlock (any state): next state UNLOCKED, relock timer loaded, fail_count<=0, partial entry cleared.
//  remote_lock (any state except with remote_unlock): next state LOCKED, partial entry cleared.
//    fail_count is kept. LOCKOUT stays LOCKOUT.
//  LOCKED + key_valid: digit stored, count<=1 and state ENTRY. If CODE_LEN==1, the digit is checked at once.
//  ENTRY + key_valid: digit shifted in. Each accepted digit reloads the entry timeout.
//  On the CODE_LEN-th digit, code = {stored digits, key_digit}, compared combinationally:
//   - match main_code, or (temp_code_en && match temp_code): UNLOCKED on next edge, fail_count<=0.
//     lock_state rises 1 cycle after the final strobe.
//   - otherwise: bad_code pulses and fail_count increments.
//     If the new count == MAX_FAILS: LOCKOUT with the timer loaded. Else LOCKED.
//  ENTRY with no key for ENTRY_TO_CYC cycles: LOCKED, partial code discarded, fail_count unchanged.
//  UNLOCKED: key_valid ignored. After RELOCK_CYC cycles: LOCKED.
//  LOCKOUT: key_valid ignored. After LOCKOUT_CYC cycles: LOCKED, fail_count<=0.
//  Timer: one down-counter shared by the relock, entry-timeout and lockout functions.
//    Width $clog2(max of the three cycle parameters)+1. Expiry = count reaches 0; no wrap.
//  fail_count saturates at MAX_FAILS.
//  Reset mid-entry or mid-lockout: immediate return to the reset state.
// STRUCTURE
//  smart_lock_pkg: state enum lock_state_e {LOCKED, ENTRY, UNLOCKED, LOCKOUT}; LOCKED/UNLOCKED constants.
//  Sub-module smart_lock_timer: loadable down-counter with load, value and expired ports.
//  Code shift register, digit counter and comparators stay inline.
// TESTING (defaults; main_code=16'h1A2B, temp_code=16'h7777)
//  1. Keys 1,A,2,B, one strobe every 3 cycles.
//     -> lock_state=1 one cycle after B; lock_state=0 exactly 500 cycles later.
//  2. temp_code_en=0, keys 7,7,7,7 -> bad_code pulse, fail_count=1.
//     Then temp_code_en=1, keys 7,7,7,7 -> unlocked, fail_count=0.
//  3. Three wrong codes (0000 x3) -> lockout=1 after the third.
//     Correct 1A2B during lockout is ignored. After 1000 cycles: lockout=0, fail_count=0.
//  4. Keys 1,A, then 200 idle cycles -> entry_busy=0.
//     Next keys 2,B,1,A fail: fail_count=1 and bad_code pulses.
//  5. During LOCKOUT, remote_unlock=1 -> unlocked, fail_count=0.
//     Same cycle remote_unlock=remote_lock=1 -> unlocked.
//  6. Assert rst mid-entry after key 2 -> all outputs 0.
//     A full 1A2B entered after release unlocks.

Source files
------------

// File: rtl/smart_lock_pkg.sv
// smart_lock_pkg
//   Shared types and constants for the smart door-lock controller.
//   - lock_state_e : controller state (LOCKED, ENTRY, UNLOCKED, LOCKOUT)
//   - LS_LOCKED / LS_UNLOCKED : values driven on the lock_state output
//   - max3() : constant helper used to size the shared timer
package smart_lock_pkg;

    typedef enum logic [1:0] {
        LOCKED   = 2'd0,
        ENTRY    = 2'd1,
        UNLOCKED = 2'd2,
        LOCKOUT  = 2'd3
    } lock_state_e;

    localparam logic LS_LOCKED   = 1'b0;
    localparam logic LS_UNLOCKED = 1'b1;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/smart_lock_timer.sv
// smart_lock_timer
//   Loadable down-counter shared by the relock, entry-timeout and lockout
//   functions. Counts down once per cycle and parks at zero (no wrap).
// Ports
//   clk      in   clock
//   rst      in   asynchronous active-high reset (clears the count)
//   load     in   load load_val this cycle (wins over counting)
//   load_val in   W  value to load
//   value    out  W  current count
//   expired  out  1 while the count is zero
module smart_lock_timer #(
    parameter int W = 11
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] value,
    output logic         expired
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (value != '0) begin
            value <= value - W'(1);
        end
    end

    assign expired = (value == '0);

endmodule

// File: rtl/smart_lock_ctrl.sv
// smart_lock_ctrl
//   Keypad/remote door-lock controller. Collects a CODE_LEN-digit code and
//   checks it against main_code and (when enabled) temp_code. Provides
//   auto-relock, an entry timeout and a lockout after MAX_FAILS bad codes.
// Ports
//   clk, rst        clock; asynchronous active-high reset
//   key_valid       one-cycle strobe, key_digit holds a new digit
//   key_digit       DIGIT_W digit value
//   main_code       CODE_LEN*DIGIT_W, first digit entered is the MS digit
//   temp_code       same ordering, accepted only while temp_code_en=1
//   remote_unlock   hub unlock request (level, sampled every cycle)
//   remote_lock     hub lock request (level, sampled every cycle)
//   lock_state      0 = locked, 1 = unlocked
//   lockout         1 while in LOCKOUT
//   entry_busy      1 while a partial code is held
//   fail_count      consecutive failed attempts (saturates at MAX_FAILS)
//   bad_code        one-cycle pulse on a wrong complete code
//   fsm_state       current controller state (debug)
//   timer_value     current shared timer count (debug)
//
// Handshake: key_valid is a pure strobe with no back-pressure. A digit is
// taken on the clock edge where key_valid=1; digits offered in UNLOCKED or
// LOCKOUT, or in a cycle where a remote request or timer expiry wins, are
// dropped.
module smart_lock_ctrl
    import smart_lock_pkg::*;
#(
    parameter int DIGIT_W      = 4,
    parameter int CODE_LEN     = 4,
    parameter int MAX_FAILS    = 3,
    parameter int LOCKOUT_CYC  = 1000,
    parameter int RELOCK_CYC   = 500,
    parameter int ENTRY_TO_CYC = 200
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 key_valid,
    input  logic [DIGIT_W-1:0]                   key_digit,
    input  logic [CODE_LEN*DIGIT_W-1:0]          main_code,
    input  logic [CODE_LEN*DIGIT_W-1:0]          temp_code,
    input  logic                                 temp_code_en,
    input  logic                                 remote_unlock,
    input  logic                                 remote_lock,
    output logic                                 lock_state,
    output logic                                 lockout,
    output logic                                 entry_busy,
    output logic [$clog2(MAX_FAILS+1)-1:0]       fail_count,
    output logic                                 bad_code,
    output lock_state_e                          fsm_state,
    output logic [$clog2(max3(LOCKOUT_CYC, RELOCK_CYC, ENTRY_TO_CYC)):0] timer_value
);

    localparam int CODE_W = CODE_LEN * DIGIT_W;
    localparam int FC_W   = $clog2(MAX_FAILS + 1);
    localparam int TMR_W  = $clog2(max3(LOCKOUT_CYC, RELOCK_CYC, ENTRY_TO_CYC)) + 1;
    localparam int CNT_W  = $clog2(CODE_LEN + 1);

    // The timer is loaded with N-1 so that the state changes exactly N
    // cycles after the load edge (the expiry is seen at count 0).
    localparam logic [TMR_W-1:0] RELOCK_LOAD  = TMR_W'(RELOCK_CYC - 1);
    localparam logic [TMR_W-1:0] ENTRY_LOAD   = TMR_W'(ENTRY_TO_CYC - 1);
    localparam logic [TMR_W-1:0] LOCKOUT_LOAD = TMR_W'(LOCKOUT_CYC - 1);

    logic [CODE_W-1:0] shreg;
    logic [CODE_W-1:0] candidate;
    logic [CNT_W-1:0]  digit_cnt;
    logic [CNT_W-1:0]  held_cnt;
    logic              key_accept;
    logic              code_complete;
    logic              code_ok;
    logic [FC_W-1:0]   fail_inc;

    lock_state_e       state_d;
    logic [FC_W-1:0]   fail_d;
    logic              bad_d;
    logic              store_digit;
    logic              tmr_load;
    logic [TMR_W-1:0]  tmr_load_val;
    logic              tmr_expired;

    smart_lock_timer #(.W(TMR_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .value    (timer_value),
        .expired  (tmr_expired)
    );

    // Digits already held; the shift register is only meaningful in ENTRY.
    assign held_cnt      = (fsm_state == ENTRY) ? digit_cnt : '0;
    assign candidate     = ((fsm_state == ENTRY) ? (shreg << DIGIT_W) : '0)
                           | CODE_W'(key_digit);
    assign key_accept    = key_valid && ((fsm_state == LOCKED) || (fsm_state == ENTRY));
    assign code_complete = (held_cnt == CNT_W'(CODE_LEN - 1));
    assign code_ok       = (candidate == main_code)
                           || (temp_code_en && (candidate == temp_code));
    assign fail_inc      = (fail_count == FC_W'(MAX_FAILS)) ? fail_count
                                                            : fail_count + FC_W'(1);

    // Next-state decision, priority: remote_unlock > remote_lock > timer > keypad.
    always_comb begin
        state_d      = fsm_state;
        fail_d       = fail_count;
        bad_d        = 1'b0;
        store_digit  = 1'b0;
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        if (remote_unlock) begin
            state_d      = UNLOCKED;
            fail_d       = '0;
            tmr_load     = 1'b1;
            tmr_load_val = RELOCK_LOAD;
        end else if (remote_lock) begin
            if (fsm_state != LOCKOUT) state_d = LOCKED;
        end else if (tmr_expired && (fsm_state != LOCKED)) begin
            state_d = LOCKED;
            if (fsm_state == LOCKOUT) fail_d = '0;
        end else if (key_accept) begin
            if (code_complete) begin
                if (code_ok) begin
                    state_d      = UNLOCKED;
                    fail_d       = '0;
                    tmr_load     = 1'b1;
                    tmr_load_val = RELOCK_LOAD;
                end else begin
                    bad_d  = 1'b1;
                    fail_d = fail_inc;
                    if (fail_inc == FC_W'(MAX_FAILS)) begin
                        state_d      = LOCKOUT;
                        tmr_load     = 1'b1;
                        tmr_load_val = LOCKOUT_LOAD;
                    end else begin
                        state_d = LOCKED;
                    end
                end
            end else begin
                state_d      = ENTRY;
                store_digit  = 1'b1;
                tmr_load     = 1'b1;
                tmr_load_val = ENTRY_LOAD;
            end
        end
    end

    // State, registered status outputs and the digit collector.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_state  <= LOCKED;
            lock_state <= LS_LOCKED;
            lockout    <= 1'b0;
            entry_busy <= 1'b0;
            fail_count <= '0;
            bad_code   <= 1'b0;
            shreg      <= '0;
            digit_cnt  <= '0;
        end else begin
            fsm_state  <= state_d;
            lock_state <= (state_d == UNLOCKED) ? LS_UNLOCKED : LS_LOCKED;
            lockout    <= (state_d == LOCKOUT);
            entry_busy <= (state_d == ENTRY);
            fail_count <= fail_d;
            bad_code   <= bad_d;
            if (store_digit) begin
                shreg     <= candidate;
                digit_cnt <= held_cnt + CNT_W'(1);
            end else if (state_d != ENTRY) begin
                // Leaving ENTRY for any reason discards the partial code.
                shreg     <= '0;
                digit_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_smart_lock_ctrl.sv
// tb_smart_lock_ctrl
//   Directed bench for smart_lock_ctrl with default parameters,
//   main_code=16'h1A2B and temp_code=16'h7777.
module tb_smart_lock_ctrl;
    import smart_lock_pkg::*;

    // Clock / reset
    logic        clk;
    logic        rst;
    logic        key_valid;
    logic [3:0]  key_digit;
    logic [15:0] main_code;
    logic [15:0] temp_code;
    logic        temp_code_en;
    logic        remote_unlock;
    logic        remote_lock;
    logic        lock_state;
    logic        lockout;
    logic        entry_busy;
    logic [1:0]  fail_count;
    logic        bad_code;
    lock_state_e fsm_state;
    logic [10:0] timer_value;

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    smart_lock_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .key_valid     (key_valid),
        .key_digit     (key_digit),
        .main_code     (main_code),
        .temp_code     (temp_code),
        .temp_code_en  (temp_code_en),
        .remote_unlock (remote_unlock),
        .remote_lock   (remote_lock),
        .lock_state    (lock_state),
        .lockout       (lockout),
        .entry_busy    (entry_busy),
        .fail_count    (fail_count),
        .bad_code      (bad_code),
        .fsm_state     (fsm_state),
        .timer_value   (timer_value)
    );

    // Checker
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Driver tasks: all called at a falling edge, all return at a falling edge
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [3:0] d);
        key_digit = d;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    // Four digits, MS first, one strobe every 3 cycles; returns just after
    // the edge that took the last digit.
    task automatic enter_code(input logic [15:0] code);
        for (int i = 3; i >= 0; i--) begin
            if (i != 3) idle(2);
            press(code[i*4 +: 4]);
        end
    endtask

    task automatic pulse_remote(input logic unl, input logic lck);
        remote_unlock = unl;
        remote_lock   = lck;
        @(negedge clk);
        remote_unlock = 1'b0;
        remote_lock   = 1'b0;
    endtask

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst           = 1'b1;
        key_valid     = 1'b0;
        key_digit     = 4'h0;
        main_code     = 16'h1A2B;
        temp_code     = 16'h7777;
        temp_code_en  = 1'b0;
        remote_unlock = 1'b0;
        remote_lock   = 1'b0;
        idle(3);

        // Reset state
        chk("rst_lock_state", lock_state, 0);
        chk("rst_lockout",    lockout, 0);
        chk("rst_entry_busy", entry_busy, 0);
        chk("rst_fail_count", fail_count, 0);
        chk("rst_bad_code",   bad_code, 0);
        chk("rst_fsm_state",  fsm_state, LOCKED);
        chk("rst_timer",      timer_value, 0);
        rst = 1'b0;

        // 1: correct main code, then auto-relock after 500 cycles
        press(4'h1); idle(2); press(4'hA); idle(2); press(4'h2); idle(2);
        chk("t1_entry_busy", entry_busy, 1);
        chk("t1_still_locked", lock_state, 0);
        press(4'hB);
        chk("t1_unlocked", lock_state, 1);
        chk("t1_busy_clear", entry_busy, 0);
        chk("t1_fail_zero", fail_count, 0);
        idle(499);
        chk("t1_relock_499", lock_state, 1);
        idle(1);
        chk("t1_relock_500", lock_state, 0);

        // 2: temp code rejected while disabled, accepted when enabled
        enter_code(16'h7777);
        chk("t2_bad_pulse", bad_code, 1);
        chk("t2_fail_1", fail_count, 1);
        chk("t2_locked", lock_state, 0);
        idle(1);
        chk("t2_bad_one_cycle", bad_code, 0);
        temp_code_en = 1'b1;
        enter_code(16'h7777);
        chk("t2_temp_unlock", lock_state, 1);
        chk("t2_fail_clear", fail_count, 0);
        chk("t2_no_bad", bad_code, 0);
        pulse_remote(1'b0, 1'b1);
        chk("t2_remote_lock", lock_state, 0);
        temp_code_en = 1'b0;

        // 3: three wrong codes -> lockout for 1000 cycles
        enter_code(16'h0000);
        chk("t3_fail_1", fail_count, 1);
        enter_code(16'h0000);
        chk("t3_fail_2", fail_count, 2);
        chk("t3_no_lockout_yet", lockout, 0);
        enter_code(16'h0000);
        chk("t3_lockout", lockout, 1);
        chk("t3_fail_3", fail_count, 3);
        chk("t3_bad_pulse", bad_code, 1);
        enter_code(16'h1A2B);
        chk("t3_ignored_unlock", lock_state, 0);
        chk("t3_still_lockout", lockout, 1);
        idle(989);
        chk("t3_lockout_999", lockout, 1);
        idle(1);
        chk("t3_lockout_end", lockout, 0);
        chk("t3_fail_reset", fail_count, 0);
        chk("t3_locked_after", lock_state, 0);

        // 4: entry timeout discards a partial code
        press(4'h1); idle(2); press(4'hA);
        chk("t4_busy", entry_busy, 1);
        idle(199);
        chk("t4_busy_199", entry_busy, 1);
        idle(1);
        chk("t4_timeout", entry_busy, 0);
        chk("t4_fail_kept", fail_count, 0);
        enter_code(16'h2B1A);
        chk("t4_bad_pulse", bad_code, 1);
        chk("t4_fail_1", fail_count, 1);
        chk("t4_locked", lock_state, 0);

        // 5: remote requests against lockout and each other
        enter_code(16'h0000);
        chk("t5_fail_2", fail_count, 2);
        enter_code(16'h0000);
        chk("t5_lockout", lockout, 1);
        pulse_remote(1'b0, 1'b1);
        chk("t5_lock_keeps_lockout", lockout, 1);
        chk("t5_lock_keeps_fail", fail_count, 3);
        pulse_remote(1'b1, 1'b0);
        chk("t5_remote_unlock", lock_state, 1);
        chk("t5_lockout_clear", lockout, 0);
        chk("t5_fail_clear", fail_count, 0);
        pulse_remote(1'b0, 1'b1);
        chk("t5_relocked", lock_state, 0);
        pulse_remote(1'b1, 1'b1);
        chk("t5_both_unlock", lock_state, 1);
        pulse_remote(1'b0, 1'b1);
        chk("t5_final_lock", lock_state, 0);

        // 6: asynchronous reset mid-entry
        enter_code(16'h0000);
        chk("t6_fail_1", fail_count, 1);
        press(4'h1); idle(2); press(4'hA); idle(2); press(4'h2);
        chk("t6_busy", entry_busy, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_lock_state", lock_state, 0);
        chk("t6_rst_entry_busy", entry_busy, 0);
        chk("t6_rst_fail_count", fail_count, 0);
        chk("t6_rst_lockout",    lockout, 0);
        chk("t6_rst_bad_code",   bad_code, 0);
        chk("t6_rst_fsm_state",  fsm_state, LOCKED);
        @(negedge clk);
        rst = 1'b0;
        enter_code(16'h1A2B);
        chk("t6_unlock_after_rst", lock_state, 1);
        chk("t6_fail_zero", fail_count, 0);

        // Final report
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
